// File: rtl/instruction_memory.sv
// Instruction memory: 2^ADDR_W words of DATA_W bits, read combinationally at busPc.
// A fixed boot program is restored on asynchronous reset.
// Optional feature macro IM_PROG_EN adds a clocked programming port.
// Without IM_PROG_EN the block is a pure ROM and clk/prog_* are ignored.
module instruction_memory #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] busPc,
  output logic [DATA_W-1:0] instruction,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // Boot program contents; every word outside the first eight is a NOP.
  function automatic logic [DATA_W-1:0] boot_word(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] w;
    w = '0;
    case (addr)
      ADDR_W'(0): w = DATA_W'(8'h10);
      ADDR_W'(1): w = DATA_W'(8'h21);
      ADDR_W'(2): w = DATA_W'(8'h32);
      ADDR_W'(3): w = DATA_W'(8'h43);
      ADDR_W'(4): w = DATA_W'(8'h54);
      ADDR_W'(5): w = DATA_W'(8'h65);
      ADDR_W'(6): w = DATA_W'(8'h76);
      ADDR_W'(7): w = DATA_W'(8'hF0);
      default:    w = '0;
    endcase
    return w;
  endfunction

`ifdef IM_PROG_EN

  logic [DATA_W-1:0] mem [DEPTH];

  // Writable storage: reset reloads the boot image, otherwise accept one write per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= boot_word(ADDR_W'(i));
      end
    end else if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Zero-latency fetch, forced to NOP while reset is held.
  always_comb begin
    instruction = '0;
    if (rst_n) begin
      instruction = mem[busPc];
    end
  end

`else

  // Programming port is present on the boundary but intentionally unused in ROM form.
  logic unused_prog;
  assign unused_prog = ^{clk, prog_we, prog_addr, prog_data};

  // Zero-latency ROM fetch, forced to NOP while reset is held.
  always_comb begin
    instruction = '0;
    if (rst_n) begin
      instruction = boot_word(busPc);
    end
  end

`endif

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory; builds with or without IM_PROG_EN.
module tb_instruction_memory;

  logic       clk;
  logic       rst_n;
  logic [7:0] busPc;
  logic [7:0] instruction;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory: plain array holding what each address should read.
  logic [7:0] model [256];
  logic [7:0] boot_tbl [8] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'hF0};

  typedef struct {
    logic       rst;
    logic [7:0] pc;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [12];

  instruction_memory #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .busPc      (busPc),
    .instruction(instruction),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    for (int i = 0; i < 8; i++) model[i] = boot_tbl[i];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // One programming write on the next rising edge, mirrored into the model.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk);
`ifdef IM_PROG_EN
    model[a] = d;
`endif
    #1 prog_we = 1'b0;
  endtask

  initial begin
    logic [7:0] a, d, pc;
    logic       we;

    rst_n = 1'b0; busPc = 8'd3; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    model_reset();

    // Reset forces NOP; release shows the word with no clock edge.
    @(negedge clk);
    #1 check("reset_hold_pc3", instruction, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_release_pc3", instruction, 8'h43);

    // Table of fetches, including a reset row and the 8-bit boundary.
    vecs[0]  = '{1'b1, 8'd0,   8'h10};
    vecs[1]  = '{1'b1, 8'd1,   8'h21};
    vecs[2]  = '{1'b1, 8'd7,   8'hF0};
    vecs[3]  = '{1'b1, 8'd200, 8'h00};
    vecs[4]  = '{1'b1, 8'd2,   8'h32};
    vecs[5]  = '{1'b1, 8'd4,   8'h54};
    vecs[6]  = '{1'b1, 8'd255, 8'h00};
    vecs[7]  = '{1'b0, 8'd7,   8'h00};
    vecs[8]  = '{1'b1, 8'd6,   8'h76};
    vecs[9]  = '{1'b1, 8'd8,   8'h00};
    vecs[10] = '{1'b1, 8'd5,   8'h65};
    vecs[11] = '{1'b1, 8'd3,   8'h43};
    for (int i = 0; i < 12; i++) begin
      rst_n = vecs[i].rst;
      busPc = vecs[i].pc;
      #2 check($sformatf("vec%0d", i), instruction, vecs[i].exp);
      #18;
    end
    rst_n = 1'b1;

`ifdef IM_PROG_EN
    // Write to the address being fetched: old word before the edge, new after.
    @(negedge clk);
    busPc = 8'd5; prog_we = 1'b1; prog_addr = 8'd5; prog_data = 8'hAB;
    #1 check("prog_before_edge", instruction, 8'h65);
    @(posedge clk);
    model[5] = 8'hAB;
    #1 check("prog_after_edge", instruction, 8'hAB);
    prog_we = 1'b0;

    // Back-to-back writes to one address: last wins.
    busPc = 8'd10;
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 8'd10; prog_data = 8'h11;
    @(negedge clk);
    check("b2b_first", instruction, 8'h11);
    prog_data = 8'h22;
    @(negedge clk);
    prog_we = 1'b0;
    model[10] = 8'h22;
    check("b2b_last", instruction, 8'h22);

    // Write 0x99 to address 0, then async reset pulse between edges restores the image.
    do_write(8'd0, 8'h99);
    busPc = 8'd0;
    #1 check("wrote_addr0", instruction, 8'h99);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("async_reset_nop", instruction, 8'h00);
    #1 rst_n = 1'b1;
    model_reset();
    #1 check("reset_restores_addr0", instruction, 8'h10);
    busPc = 8'd10;
    #1 check("reset_restores_addr10", instruction, 8'h00);

    // Reset held across a write edge: the write is lost.
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 8'd3; prog_data = 8'h77; rst_n = 1'b0;
    @(posedge clk);
    #1 prog_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; busPc = 8'd3;
    #1 check("write_lost_in_reset", instruction, 8'h43);
`else
    // ROM build: programming port has no effect.
    do_write(8'd1, 8'h55);
    busPc = 8'd1;
    #1 check("rom_ignores_write", instruction, 8'h21);
`endif

    // Disabled write enable leaves memory unchanged.
    @(negedge clk);
    prog_we = 1'b0; prog_addr = 8'd2; prog_data = 8'hFF;
    @(posedge clk);
    #1 busPc = 8'd2;
    #1 check("we_low_no_write", instruction, 8'h32);

    // Randomized writes, fetches and occasional reset pulses against the model.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      we = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 15));
      d  = 8'($urandom);
      pc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      prog_we = we; prog_addr = a; prog_data = d; busPc = pc;
      #1 check("rand_pre_edge", instruction, model[pc]);
      @(posedge clk);
`ifdef IM_PROG_EN
      if (we) model[a] = d;
`endif
      #1 check("rand_post_edge", instruction, model[pc]);
      prog_we = 1'b0;
      if ($urandom_range(0, 40) == 0) begin
        #1 rst_n = 1'b0;
        #1 check("rand_reset_nop", instruction, 8'h00);
        rst_n = 1'b1;
        model_reset();
        #0.5 check("rand_after_reset", instruction, model[pc]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
